// File: rtl/io_port_bridge_if.sv
// Data-access bus between the processor data path, DataMemory, the port pins and the TX consumer.
// The bridge connects through the slave modport; the processor/testbench side uses master.
interface io_port_bridge_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemReadData;
    logic [31:0] ReadData;
    logic        MemWriteOut;
    logic        MemReadOut;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;

    modport slave (
        input  Address, WriteData, MemWrite, MemRead, MemReadData, PortIn, TxReady,
        output ReadData, MemWriteOut, MemReadOut, PortOut, TxData, TxValid
    );

    modport master (
        output Address, WriteData, MemWrite, MemRead, MemReadData, PortIn, TxReady,
        input  ReadData, MemWriteOut, MemReadOut, PortOut, TxData, TxValid
    );
endinterface

// File: rtl/io_port_bridge.sv
// Memory-mapped I/O bridge: PORT_OUT / PORT_IN / STATUS / TX_DATA window in front of DataMemory.
// Define IO_BRIDGE_DEBOUNCE_EN to debounce the synchronized PortIn before it reaches in_sync.
module io_port_bridge #(
    parameter logic [31:0] BASE_ADDR       = 32'h1001_0400,
    parameter int          FIFO_DEPTH      = 8,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    io_port_bridge_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] OFF_PORT_OUT = 2'd0;
    localparam logic [1:0] OFF_PORT_IN  = 2'd1;
    localparam logic [1:0] OFF_STATUS   = 2'd2;
    localparam logic [1:0] OFF_TX_DATA  = 2'd3;

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
            $error("io_port_bridge: FIFO_DEPTH must be a power of 2 >= 2 and DEBOUNCE_CYCLES >= 1");
        end
    endgenerate

    // Byte lanes inside a word are not decoded; every access is a full-word access.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.Address[1:0];

    logic       io_hit;
    logic [1:0] offset;
    assign io_hit = (bus.Address[31:4] == BASE_ADDR[31:4]);
    assign offset = bus.Address[3:2];

    logic [31:0]      port_out_q, port_out_d;
    logic [7:0]       sync1_q, sync2_q;
    logic [7:0]       in_sync;
    logic [7:0]       in_prev_q;
    logic             changed_q, changed_d;
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];

    logic push_req, push, pop, full, empty, status_rd, tx_valid;
    logic [31:0] status;

`ifdef IO_BRIDGE_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [7:0]       deb_cand_q;
    logic [7:0]       in_sync_q, in_sync_d;

    // The candidate must hold DEBOUNCE_CYCLES consecutive samples; any change restarts the run.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        in_sync_d = in_sync_q;
        if (sync2_q != deb_cand_q) begin
            deb_cnt_d = DEB_W'(1);
        end else begin
            if (deb_cnt_q != DEB_W'(DEBOUNCE_CYCLES)) deb_cnt_d = deb_cnt_q + DEB_W'(1);
            if (deb_cnt_q >= DEB_W'(DEBOUNCE_CYCLES - 1)) in_sync_d = deb_cand_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt_q  <= '0;
            deb_cand_q <= '0;
            in_sync_q  <= '0;
        end else begin
            deb_cnt_q  <= deb_cnt_d;
            deb_cand_q <= sync2_q;
            in_sync_q  <= in_sync_d;
        end
    end

    assign in_sync = in_sync_q;
`else
    assign in_sync = sync2_q;
`endif

    assign tx_valid  = (count_q != '0);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign push_req  = bus.MemWrite & io_hit & (offset == OFF_TX_DATA);
    assign push      = push_req & ~full;
    assign pop       = tx_valid & bus.TxReady;
    assign status_rd = bus.MemRead & io_hit & (offset == OFF_STATUS);
    assign status    = {27'b0, overflow_q, changed_q, empty, full, tx_valid};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        port_out_d = port_out_q;
        if (bus.MemWrite && io_hit && offset == OFF_PORT_OUT) port_out_d = bus.WriteData;

        // Sticky flags: a set event in the same cycle as a STATUS read wins.
        changed_d  = (in_sync != in_prev_q) | (changed_q & ~status_rd);
        overflow_d = (push_req & full)      | (overflow_q & ~status_rd);

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            port_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            in_prev_q  <= '0;
            changed_q  <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            port_out_q <= port_out_d;
            sync1_q    <= bus.PortIn;
            sync2_q    <= sync1_q;
            in_prev_q  <= in_sync;
            changed_q  <= changed_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: FIFO storage has no reset; stale bytes are masked because count_q is cleared.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= bus.WriteData[7:0];
    end

    always_comb begin
        bus.ReadData    = bus.MemReadData;
        bus.MemWriteOut = bus.MemWrite;
        bus.MemReadOut  = bus.MemRead;
        if (io_hit) begin
            bus.MemWriteOut = 1'b0;
            bus.MemReadOut  = 1'b0;
            case (offset)
                OFF_PORT_OUT: bus.ReadData = port_out_q;
                OFF_PORT_IN:  bus.ReadData = {24'b0, in_sync};
                OFF_STATUS:   bus.ReadData = status;
                default:      bus.ReadData = '0;
            endcase
        end
    end

    assign bus.PortOut = port_out_q;
    assign bus.TxValid = tx_valid;
    assign bus.TxData  = tx_valid ? fifo_mem_q[rd_ptr_q] : 8'h00;
endmodule

// File: tb/tb_io_port_bridge.sv
// Directed testbench for io_port_bridge (default build, debounce disabled).
// Inputs change 1 ns after a rising edge; outputs are checked before the next edge.
module tb_io_port_bridge;
    localparam logic [31:0] A_PORT_OUT = 32'h1001_0400;
    localparam logic [31:0] A_PORT_IN  = 32'h1001_0404;
    localparam logic [31:0] A_STATUS   = 32'h1001_0408;
    localparam logic [31:0] A_TX_DATA  = 32'h1001_040C;
    localparam logic [31:0] MEM_DATA   = 32'hCAFE_F00D;

    logic clk;
    logic reset;
    int   check_cnt = 0;
    int   pass_cnt  = 0;

    io_port_bridge_if bus ();

    io_port_bridge u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        bus.Address   = addr;
        bus.WriteData = data;
        bus.MemWrite  = 1'b1;
        next_cycle();
        bus.MemWrite  = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.Address = addr;
        bus.MemRead = 1'b1;
        #1;
        check(tag, bus.ReadData, exp);
        next_cycle();
        bus.MemRead = 1'b0;
    endtask

    initial begin
        bus.Address     = '0;
        bus.WriteData   = '0;
        bus.MemWrite    = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemReadData = MEM_DATA;
        bus.PortIn      = 8'h00;
        bus.TxReady     = 1'b0;
        reset           = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_port_out", bus.PortOut, 32'h0);
        check("rst_tx_valid", {31'b0, bus.TxValid}, 32'h0);
        check("rst_tx_data", {24'b0, bus.TxData}, 32'h0);
        load_chk("rst_status", A_STATUS, 32'h4);

        // PORT_OUT store and load
        bus.Address   = A_PORT_OUT;
        bus.WriteData = 32'hDEAD_BEEF;
        bus.MemWrite  = 1'b1;
        #1 check("hit_wr_gated", {31'b0, bus.MemWriteOut}, 32'h0);
        next_cycle();
        bus.MemWrite = 1'b0;
        check("port_out_store", bus.PortOut, 32'hDEAD_BEEF);
        bus.MemRead = 1'b1;
        #1 check("hit_rd_gated", {31'b0, bus.MemReadOut}, 32'h0);
        bus.MemRead = 1'b0;
        load_chk("port_out_load", A_PORT_OUT, 32'hDEAD_BEEF);

        // Pass-through to DataMemory
        bus.Address   = 32'h1001_0000;
        bus.WriteData = 32'h1111_2222;
        bus.MemWrite  = 1'b1;
        #1 check("miss_wr_pass", {31'b0, bus.MemWriteOut}, 32'h1);
        check("miss_rd_idle", {31'b0, bus.MemReadOut}, 32'h0);
        next_cycle();
        bus.MemWrite = 1'b0;
        check("miss_port_out_kept", bus.PortOut, 32'hDEAD_BEEF);
        bus.MemRead = 1'b1;
        #1 check("miss_rd_pass", {31'b0, bus.MemReadOut}, 32'h1);
        check("miss_rd_data", bus.ReadData, MEM_DATA);
        next_cycle();
        bus.MemRead = 1'b0;

        // Window edges: just above and just below are misses
        bus.Address  = 32'h1001_0410;
        bus.MemWrite = 1'b1;
        #1 check("edge_above_miss", {31'b0, bus.MemWriteOut}, 32'h1);
        bus.Address = 32'h1001_03FC;
        #1 check("edge_below_miss", {31'b0, bus.MemWriteOut}, 32'h1);
        bus.MemWrite = 1'b0;
        next_cycle();

        // Unaligned address maps to the PORT_OUT word
        store(32'h1001_0403, 32'h0BAD_F00D);
        check("unaligned_store", bus.PortOut, 32'h0BAD_F00D);

        // PortIn synchronizer and sticky changed flag
        bus.PortIn = 8'hA5;
        next_cycle();
        load_chk("port_in_early", A_PORT_IN, 32'h0);
        load_chk("port_in_sync", A_PORT_IN, 32'h0000_00A5);
        load_chk("status_changed", A_STATUS, 32'h0000_000C);
        load_chk("status_cleared", A_STATUS, 32'h0000_0004);

        // Fill past capacity with the consumer stalled
        for (int i = 1; i <= 9; i++) store(A_TX_DATA, 32'(i));
        check("fill_tx_valid", {31'b0, bus.TxValid}, 32'h1);
        check("fill_head", {24'b0, bus.TxData}, 32'h01);
        load_chk("tx_data_reads_zero", A_TX_DATA, 32'h0);
        load_chk("status_full_ovf", A_STATUS, 32'h0000_0013);
        check("head_held", {24'b0, bus.TxData}, 32'h01);
        bus.TxReady = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain_valid_%0d", i), {31'b0, bus.TxValid}, 32'h1);
            check($sformatf("drain_data_%0d", i), {24'b0, bus.TxData}, 32'(i));
            next_cycle();
        end
        check("drained_valid", {31'b0, bus.TxValid}, 32'h0);
        bus.TxReady = 1'b0;
        load_chk("status_drained", A_STATUS, 32'h0000_0004);

        // Simultaneous push and pop with three entries queued
        for (int i = 0; i < 3; i++) store(A_TX_DATA, 32'h21 + 32'(i));
        bus.Address   = A_TX_DATA;
        bus.WriteData = 32'h24;
        bus.MemWrite  = 1'b1;
        bus.TxReady   = 1'b1;
        #1 check("pp_head_before", {24'b0, bus.TxData}, 32'h21);
        next_cycle();
        bus.MemWrite = 1'b0;
        bus.TxReady  = 1'b0;
        check("pp_head_after", {24'b0, bus.TxData}, 32'h22);
        load_chk("pp_status", A_STATUS, 32'h0000_0001);
        bus.TxReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pp_drain_%0d", i), {24'b0, bus.TxData}, 32'h22 + 32'(i));
            next_cycle();
        end
        check("pp_drained_valid", {31'b0, bus.TxValid}, 32'h0);
        bus.TxReady = 1'b0;

        // Reset in the middle of a transfer
        store(A_PORT_OUT, 32'h55);
        for (int i = 0; i < 4; i++) store(A_TX_DATA, 32'h31 + 32'(i));
        check("pre_rst_valid", {31'b0, bus.TxValid}, 32'h1);
        check("pre_rst_port_out", bus.PortOut, 32'h55);
        bus.TxReady = 1'b1;
        reset       = 1'b1;
        next_cycle();
        reset       = 1'b0;
        bus.TxReady = 1'b0;
        check("mid_rst_valid", {31'b0, bus.TxValid}, 32'h0);
        check("mid_rst_data", {24'b0, bus.TxData}, 32'h0);
        check("mid_rst_port_out", bus.PortOut, 32'h0);
        load_chk("mid_rst_status", A_STATUS, 32'h0000_0004);
        store(A_TX_DATA, 32'h77);
        check("post_rst_push", {24'b0, bus.TxData}, 32'h77);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
